// File: rtl/pending_encoder8_3.sv
// Pending-request set with round-robin index encoder and a saturating
// count of accepted pops. Outputs decode registered state only.
module pending_encoder8_3 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       enable,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] idx,
  output logic [7:0] onehot,
  output logic [7:0] pending,
  output logic [3:0] served
);

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [IDX_W-1:0] PTR_RST = 3'd7;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  logic [NREQ-1:0]  r_pend;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_valid;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [NREQ-1:0]  w_onehot;
  logic             w_pop;
  logic [NREQ-1:0]  w_pend_nxt;

  // Round-robin scan starting just after the last served bit, ending at it.
  always_comb begin
    logic [IDX_W-1:0] pos;
    w_found = 1'b0;
    w_idx   = '0;
    pos     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = IDX_W'(r_ptr + IDX_W'(k));
      if (!w_found && r_pend[pos]) begin
        w_found = 1'b1;
        w_idx   = pos;
      end
    end
  end

  // Output decode, gated so idx/onehot read zero when nothing is pending.
  always_comb begin
    w_valid  = |r_pend;
    w_onehot = w_valid ? NREQ'(NREQ'(1) << w_idx) : '0;
    w_pop    = w_valid & ready;
    // Clear the popped bit first so a same-cycle re-request keeps it set.
    w_pend_nxt = (r_pend & ~(w_pop ? w_onehot : '0)) | (enable ? req : '0);
  end

  // State update: reset overrides any capture or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_ptr  <= PTR_RST;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_pop) begin
        r_ptr <= w_idx;
        if (r_cnt != CNT_MAX) begin
          r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
        end
      end
    end
  end

  assign valid   = w_valid;
  assign idx     = w_valid ? w_idx : '0;
  assign onehot  = w_onehot;
  assign pending = r_pend;
  assign served  = r_cnt;

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Directed bench for pending_encoder8_3 with hand-computed expectations.
module tb_pending_encoder8_3;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       enable;
  logic       ready;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] onehot;
  logic [7:0] pending;
  logic [3:0] served;

  int n_vec;
  int n_err;

  pending_encoder8_3 dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .enable  (enable),
    .ready   (ready),
    .valid   (valid),
    .idx     (idx),
    .onehot  (onehot),
    .pending (pending),
    .served  (served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [2:0] i,
                         input logic [7:0] oh, input logic [7:0] p, input logic [3:0] s);
    chk({tag, ".valid"},   8'(valid),   8'(v));
    chk({tag, ".idx"},     8'(idx),     8'(i));
    chk({tag, ".onehot"},  onehot,      oh);
    chk({tag, ".pending"}, pending,     p);
    chk({tag, ".served"},  8'(served),  8'(s));
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b1;
    req    = 8'h00;
    enable = 1'b0;
    ready  = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all("rst", 1'b0, 3'd0, 8'h00, 8'h00, 4'd0);

    // Single request, one-cycle latency, not consumed
    reset = 1'b0; req = 8'h01; enable = 1'b1; ready = 1'b0;
    tick();
    req = 8'h00;
    chk_all("single", 1'b1, 3'd0, 8'h01, 8'h01, 4'd0);
    tick();
    chk("single_hold", pending, 8'h01);

    // Pop it
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk_all("single_pop", 1'b0, 3'd0, 8'h00, 8'h00, 4'd1);

    // Ready with nothing pending: no effect on served
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("idle_ready", 8'(served), 8'd1);

    // Reset again so ptr=7, then drain A5 in order 0,2,5,7
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 8'hA5;
    tick();
    req = 8'h00;
    ready = 1'b1;
    chk_all("a5_0", 1'b1, 3'd0, 8'h01, 8'hA5, 4'd0);
    tick();
    chk_all("a5_2", 1'b1, 3'd2, 8'h04, 8'hA4, 4'd1);
    tick();
    chk_all("a5_5", 1'b1, 3'd5, 8'h20, 8'hA0, 4'd2);
    tick();
    chk_all("a5_7", 1'b1, 3'd7, 8'h80, 8'h80, 4'd3);
    tick();
    chk_all("a5_done", 1'b0, 3'd0, 8'h00, 8'h00, 4'd4);
    ready = 1'b0;

    // Wrap: ptr=7, pend=81 -> idx 0 then 7
    req = 8'h81;
    tick();
    req = 8'h00;
    chk_all("wrap_0", 1'b1, 3'd0, 8'h01, 8'h81, 4'd4);
    ready = 1'b1;
    tick();
    chk_all("wrap_7", 1'b1, 3'd7, 8'h80, 8'h80, 4'd5);
    tick();
    ready = 1'b0;
    chk_all("wrap_done", 1'b0, 3'd0, 8'h00, 8'h00, 4'd6);

    // Pop and re-request same bit: set wins
    req = 8'h04;
    tick();
    chk_all("reset_win_pre", 1'b1, 3'd2, 8'h04, 8'h04, 4'd6);
    ready = 1'b1;
    tick();
    chk("setwins_pend", pending, 8'h04);
    chk("setwins_cnt", 8'(served), 8'd7);
    req = 8'h00;
    tick();
    ready = 1'b0;
    chk_all("setwins_drain", 1'b0, 3'd0, 8'h00, 8'h00, 4'd8);

    // enable=0 ignores requests
    enable = 1'b0; req = 8'hFF;
    tick();
    chk("en0_pend", pending, 8'h00);
    chk("en0_valid", 8'(valid), 8'd0);

    // Fill all, then 20 pops with continuous re-request; ptr=2 so idx 3,4,...
    enable = 1'b1;
    tick();
    chk("fill", pending, 8'hFF);
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("rr_idx%0d", i), 8'(idx), 8'((3 + i) % 8));
      tick();
      chk($sformatf("rr_cnt%0d", i), 8'(served), 8'((8 + i + 1 > 15) ? 15 : 8 + i + 1));
    end
    chk("sat_pend", pending, 8'hFF);

    // Mid-drain reset overrides request and pop
    ready = 1'b0; req = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 8'h3C;
    tick();
    req = 8'h00;
    ready = 1'b1;
    tick();
    chk_all("mid_drain", 1'b1, 3'd3, 8'h08, 8'h38, 4'd1);
    reset = 1'b1; req = 8'hFF;
    tick();
    reset = 1'b0; req = 8'h00; ready = 1'b0;
    chk_all("mid_reset", 1'b0, 3'd0, 8'h00, 8'h00, 4'd0);

    // First pick after reset scans from bit 0
    req = 8'h81;
    tick();
    req = 8'h00;
    chk_all("post_rst", 1'b1, 3'd0, 8'h01, 8'h81, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pending_encoder8_3.md
PENDING_ENCODER8_3 -- requirements
Module: pending_encoder8_3

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Port: clk  input  1  system clock.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: req  input  8  request bits; each set bit is ORed into the pending set on the next edge.
REQ-005 Port: enable  input  1  when 0, req is ignored (no new bits captured); pops still proceed.
REQ-006 Port: ready  input  1  consumer accepts the current index this cycle.
REQ-007 Port: valid  output  1  at least one pending bit exists.
REQ-008 Port: idx  output  3  encoded index of the selected pending bit.
REQ-009 Port: onehot  output  8  one-hot form of idx, gated by valid (all zero when valid=0).
REQ-010 Port: pending  output  8  current pending-set register.
REQ-011 Port: served  output  4  saturating count of accepted pops.

Function
REQ-012 State SHALL be: pend[7:0], last pointer ptr[2:0], served counter cnt[3:0]; no other storage.
REQ-013 valid, idx, onehot and pending SHALL be combinational functions of registered state only; there is no combinational path from req/enable/ready to any output.
REQ-014 valid SHALL equal OR of pend.
REQ-015 Selection SHALL be round-robin: idx = first set bit of pend scanning ptr+1, ptr+2, ... mod 8, ending at ptr itself.
REQ-016 When valid=0, idx SHALL be 0 and onehot 8'h00.
REQ-017 Pop: when valid=1 and ready=1 at an edge, bit idx SHALL be cleared, ptr SHALL load idx, cnt SHALL increment.
REQ-018 ready with valid=0 SHALL have no effect (ptr, cnt unchanged).
REQ-019 Capture: when enable=1, next pend = (pend with popped bit cleared) OR req.
REQ-020 Simultaneous pop and re-request of the same bit SHALL leave that bit set (set wins over clear).
REQ-021 Latency: req asserted at edge N SHALL be visible on pending/valid in the cycle after edge N (one-cycle).
REQ-022 Requests for bits already pending SHALL merge (no double count; no overflow condition exists).
REQ-023 cnt SHALL saturate at 4'hF; further pops leave it at 15.
REQ-024 ptr wrap-around: after serving bit 7, scan SHALL restart at bit 0.
REQ-025 At most one bit SHALL be popped per cycle.

Reset
REQ-026 reset=1 at an edge SHALL force pend=8'h00, ptr=3'd7, cnt=4'h0, overriding any simultaneous req or pop.
REQ-027 After reset, outputs SHALL read valid=0, idx=0, onehot=8'h00, pending=8'h00, served=0.
REQ-028 Reset mid-operation SHALL discard all pending bits; with ptr=7, the first post-reset pick scans from bit 0.

Verification
REQ-029 Reset, then req=8'h01 enable=1 one cycle, ready=0 -> next cycle valid=1 idx=0 onehot=8'h01 pending=8'h01.
REQ-030 req=8'hA5 loaded, ready held 1 -> idx sequence 0,2,5,7 on consecutive cycles, then valid=0, served=4.
REQ-031 ptr=7 after serving bit 7, pend=8'h81 -> next idx=0 (wrap), then 7.
REQ-032 pend=8'h04 idx=2, ready=1 and req=8'h04 same cycle -> pending stays 8'h04, served increments by 1.
REQ-033 enable=0 with req=8'hFF -> pending unchanged; 20 consecutive pops with continuous re-request -> served saturates at 15.
REQ-034 pend=8'h3C mid-drain, reset=1 with req=8'hFF and ready=1 -> pending=8'h00 valid=0 served=0 next cycle.
